// File: rtl/pistorm_bus_arbiter_if.sv
// Bus-side signals of the 68000 arbiter: external master handshake plus the
// hold/release controls seen by the PiStorm bus FSM.
interface pistorm_bus_arbiter_if;
   logic m68k_clk;
   logic m68k_br_n;
   logic m68k_bgack_n;
   logic m68k_as_n;
   logic bus_idle;
   logic m68k_bg_n;
   logic hold_req;
   logic drv_release;
   logic pi_bus_lost;
   logic arb_timeout;

   modport slave (
      input  m68k_clk,
      input  m68k_br_n,
      input  m68k_bgack_n,
      input  m68k_as_n,
      input  bus_idle,
      output m68k_bg_n,
      output hold_req,
      output drv_release,
      output pi_bus_lost,
      output arb_timeout
   );

   modport master (
      output m68k_clk,
      output m68k_br_n,
      output m68k_bgack_n,
      output m68k_as_n,
      output bus_idle,
      input  m68k_bg_n,
      input  hold_req,
      input  drv_release,
      input  pi_bus_lost,
      input  arb_timeout
   );
endinterface

// File: rtl/pistorm_bus_arbiter.sv
// 68000 BR/BG/BGACK arbiter between the PiStorm bus FSM and external masters.
// Define PISTORM_ARB_TIMEOUT_EN to withdraw grants that are never acknowledged.
module pistorm_bus_arbiter #(
   parameter int SYNC_STAGES   = 2,
   parameter int RECOVER_CLKS  = 2,
   parameter int GRANT_TIMEOUT = 16
) (
   input logic c200m,
   input logic rst_n,
   pistorm_bus_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      OWN,
      PEND,
      GRANT,
      OWNED,
      RECOVER
   } state_t;

   localparam logic [3:0] RECOVER_LIMIT = 4'(RECOVER_CLKS);

   state_t                 state;
   logic [SYNC_STAGES-1:0] br_sync;
   logic [SYNC_STAGES-1:0] bgack_sync;
   logic [SYNC_STAGES-1:0] as_sync;
   logic [2:0]             clk_sync;
   logic                   br_s;
   logic                   bgack_s;
   logic                   as_s;
   logic                   c7m_fall;
   logic [3:0]             rec_cnt;
   logic                   bg_n_q;
   logic                   hold_q;
   logic                   release_q;
   logic                   lost_q;

   // Everything idles high; M68K_CLK is treated as plain data.
   always_ff @(posedge c200m or negedge rst_n) begin
      if (!rst_n) begin
         br_sync    <= '1;
         bgack_sync <= '1;
         as_sync    <= '1;
         clk_sync   <= '1;
      end else begin
         br_sync    <= {br_sync[SYNC_STAGES-2:0], bus.m68k_br_n};
         bgack_sync <= {bgack_sync[SYNC_STAGES-2:0], bus.m68k_bgack_n};
         as_sync    <= {as_sync[SYNC_STAGES-2:0], bus.m68k_as_n};
         clk_sync   <= {clk_sync[1:0], bus.m68k_clk};
      end
   end

   assign br_s     = br_sync[SYNC_STAGES-1];
   assign bgack_s  = bgack_sync[SYNC_STAGES-1];
   assign as_s     = as_sync[SYNC_STAGES-1];
   assign c7m_fall = clk_sync[2] & ~clk_sync[1];

`ifdef PISTORM_ARB_TIMEOUT_EN
   localparam logic [7:0] GRANT_LIMIT = 8'(GRANT_TIMEOUT);

   logic [7:0] grant_cnt;
   logic [7:0] grant_cnt_next;
   logic       timeout_q;

   // Saturates so an unacknowledged grant past the limit cannot wrap around.
   assign grant_cnt_next = (grant_cnt == 8'hFF) ? grant_cnt : grant_cnt + 8'd1;
`else
   localparam int unused_grant_timeout = GRANT_TIMEOUT;
`endif

   // Arbitration FSM; it only moves on a c7m falling edge so BG changes on a
   // clean 68000 clock boundary.
   always_ff @(posedge c200m or negedge rst_n) begin
      if (!rst_n) begin
         state     <= OWN;
         rec_cnt   <= '0;
         bg_n_q    <= 1'b1;
         hold_q    <= 1'b0;
         release_q <= 1'b0;
         lost_q    <= 1'b0;
`ifdef PISTORM_ARB_TIMEOUT_EN
         grant_cnt <= '0;
         timeout_q <= 1'b0;
`endif
      end else if (c7m_fall) begin
         unique case (state)
            OWN: begin
               if (!br_s) begin
                  state  <= PEND;
                  hold_q <= 1'b1;
               end
            end
            PEND: begin
               if (br_s) begin
                  state  <= OWN;
                  hold_q <= 1'b0;
               end else if (bus.bus_idle && as_s) begin
                  state     <= GRANT;
                  bg_n_q    <= 1'b0;
                  release_q <= 1'b1;
                  lost_q    <= 1'b1;
`ifdef PISTORM_ARB_TIMEOUT_EN
                  grant_cnt <= '0;
`endif
               end
            end
            GRANT: begin
               if (!bgack_s && as_s) begin
                  state  <= OWNED;
                  bg_n_q <= 1'b1;
               end else if (br_s) begin
                  state   <= RECOVER;
                  bg_n_q  <= 1'b1;
                  rec_cnt <= '0;
               end
`ifdef PISTORM_ARB_TIMEOUT_EN
               else if (bgack_s && (grant_cnt_next >= GRANT_LIMIT)) begin
                  state     <= RECOVER;
                  bg_n_q    <= 1'b1;
                  rec_cnt   <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  grant_cnt <= grant_cnt_next;
               end
`endif
            end
            OWNED: begin
               if (bgack_s && !br_s) begin
                  state  <= GRANT;
                  bg_n_q <= 1'b0;
`ifdef PISTORM_ARB_TIMEOUT_EN
                  grant_cnt <= '0;
`endif
               end else if (bgack_s) begin
                  state   <= RECOVER;
                  rec_cnt <= '0;
               end
            end
            RECOVER: begin
               if (!br_s) begin
                  state   <= GRANT;
                  bg_n_q  <= 1'b0;
                  rec_cnt <= '0;
`ifdef PISTORM_ARB_TIMEOUT_EN
                  grant_cnt <= '0;
`endif
               end else if (rec_cnt + 4'd1 >= RECOVER_LIMIT) begin
                  state     <= OWN;
                  rec_cnt   <= '0;
                  hold_q    <= 1'b0;
                  release_q <= 1'b0;
                  lost_q    <= 1'b0;
               end else begin
                  rec_cnt <= rec_cnt + 4'd1;
               end
            end
            default: begin
               state     <= OWN;
               rec_cnt   <= '0;
               bg_n_q    <= 1'b1;
               hold_q    <= 1'b0;
               release_q <= 1'b0;
               lost_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m68k_bg_n   = bg_n_q;
   assign bus.hold_req    = hold_q;
   assign bus.drv_release = release_q;
   assign bus.pi_bus_lost = lost_q;
`ifdef PISTORM_ARB_TIMEOUT_EN
   assign bus.arb_timeout = timeout_q;
`else
   assign bus.arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pistorm_bus_arbiter.sv
// Self-checking bench for pistorm_bus_arbiter: directed scenarios plus random
// handshake traffic compared every cycle against an ownership model.
module tb_pistorm_bus_arbiter;

   localparam int SYNC          = 2;
   localparam int RECOVER       = 2;
   localparam int GRANT_TIMEOUT = 16;

   localparam int PH_OWN     = 0;
   localparam int PH_PEND    = 1;
   localparam int PH_GRANT   = 2;
   localparam int PH_OWNED   = 3;
   localparam int PH_RECOVER = 4;

   logic c200m = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   failures = 0;
   logic cmp_en = 1'b0;

   pistorm_bus_arbiter_if bus();

   pistorm_bus_arbiter #(
      .SYNC_STAGES  (SYNC),
      .RECOVER_CLKS (RECOVER),
      .GRANT_TIMEOUT(GRANT_TIMEOUT)
   ) dut (
      .c200m(c200m),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 c200m = ~c200m;

   // Model state: who owns the bus, plus delay lines standing in for the
   // synchroniser latency the design sees on each input.
   int         m_phase = PH_OWN;
   int         m_rcnt = 0;
   int         m_gcnt = 0;
   logic       m_timeout = 1'b0;
   logic       m_fall = 1'b0;
   logic [7:0] br_h = '1;
   logic [7:0] bgack_h = '1;
   logic [7:0] as_h = '1;
   logic [7:0] clk_h = '1;

   function automatic logic exp_bg_n();
      return (m_phase == PH_GRANT) ? 1'b0 : 1'b1;
   endfunction

   function automatic logic exp_released();
      return (m_phase == PH_GRANT || m_phase == PH_OWNED || m_phase == PH_RECOVER);
   endfunction

   function automatic logic exp_hold();
      return (m_phase != PH_OWN);
   endfunction

   task automatic model_step(input logic br, input logic bgack, input logic as_n, input logic idle);
      case (m_phase)
         PH_OWN:  if (!br) m_phase = PH_PEND;
         PH_PEND: begin
            if (br) m_phase = PH_OWN;
            else if (idle && as_n) begin m_phase = PH_GRANT; m_gcnt = 0; end
         end
         PH_GRANT: begin
            if (!bgack && as_n) m_phase = PH_OWNED;
            else if (br) begin m_phase = PH_RECOVER; m_rcnt = 0; end
`ifdef PISTORM_ARB_TIMEOUT_EN
            else begin
               m_gcnt = (m_gcnt >= 255) ? 255 : m_gcnt + 1;
               if (bgack && m_gcnt >= GRANT_TIMEOUT) begin
                  m_phase = PH_RECOVER; m_rcnt = 0; m_timeout = 1'b1;
               end
            end
`endif
         end
         PH_OWNED: begin
            if (bgack && !br) begin m_phase = PH_GRANT; m_gcnt = 0; end
            else if (bgack) begin m_phase = PH_RECOVER; m_rcnt = 0; end
         end
         PH_RECOVER: begin
            if (!br) begin m_phase = PH_GRANT; m_gcnt = 0; m_rcnt = 0; end
            else begin
               m_rcnt = m_rcnt + 1;
               if (m_rcnt >= RECOVER) begin m_phase = PH_OWN; m_rcnt = 0; end
            end
         end
         default: m_phase = PH_OWN;
      endcase
   endtask

   initial begin
      forever begin
         @(posedge c200m or negedge rst_n);
         if (!rst_n) begin
            m_phase = PH_OWN; m_rcnt = 0; m_gcnt = 0; m_timeout = 1'b0; m_fall = 1'b0;
            br_h = '1; bgack_h = '1; as_h = '1; clk_h = '1;
         end else begin
            m_fall = clk_h[2] & ~clk_h[1];
            if (m_fall) model_step(br_h[SYNC-1], bgack_h[SYNC-1], as_h[SYNC-1], bus.bus_idle);
            br_h    = {br_h[6:0], bus.m68k_br_n};
            bgack_h = {bgack_h[6:0], bus.m68k_bgack_n};
            as_h    = {as_h[6:0], bus.m68k_as_n};
            clk_h   = {clk_h[6:0], bus.m68k_clk};
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic br, input logic bgack, input logic as_n, input logic idle);
      bus.m68k_br_n    = br;
      bus.m68k_bgack_n = bgack;
      bus.m68k_as_n    = as_n;
      bus.bus_idle     = idle;
   endtask

   task automatic wait_falls(input int n);
      int seen = 0;
      for (int k = 0; k < n * 64 && seen < n; k++) begin
         @(posedge c200m);
         #1;
         if (m_fall) seen++;
      end
      if (seen < n) checkOutput("fall_wait_expired", seen, n);
   endtask

   initial begin
      bus.m68k_clk = 1'b0;
      forever begin
         repeat (4) @(posedge c200m);
         #1 bus.m68k_clk = ~bus.m68k_clk;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge c200m);
         if (cmp_en) begin
            checkOutput("bg_n", bus.m68k_bg_n, exp_bg_n());
            checkOutput("hold_req", bus.hold_req, exp_hold());
            checkOutput("drv_release", bus.drv_release, exp_released());
            checkOutput("pi_bus_lost", bus.pi_bus_lost, exp_released());
            checkOutput("arb_timeout", bus.arb_timeout, m_timeout);
         end
      end
   end

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  n;
      logic br, bgack, as_n, idle;

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      rst_n = 1'b0;
      repeat (3) @(posedge c200m);
      #1;
      checkOutput("reset_bg_n", bus.m68k_bg_n, 1'b1);
      checkOutput("reset_hold", bus.hold_req, 1'b0);
      checkOutput("reset_release", bus.drv_release, 1'b0);
      checkOutput("reset_lost", bus.pi_bus_lost, 1'b0);
      checkOutput("reset_timeout", bus.arb_timeout, 1'b0);
      cmp_en = 1'b1;
      @(posedge c200m);
      #1 rst_n = 1'b1;
      wait_falls(2);

      // Basic DMA: request, grant, acknowledge, release, recovery.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("dma_pend_hold", bus.hold_req, 1'b1);
      n = 0;
      while (n < 4 && bus.m68k_bg_n !== 1'b0) begin wait_falls(1); n++; end
      checkOutput("dma_grant_within_2", (n >= 1 && n <= 2), 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("dma_owned_bg_n", bus.m68k_bg_n, 1'b1);
      checkOutput("dma_owned_release", bus.drv_release, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("dma_still_owned", bus.drv_release, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      wait_falls(1);
      for (int i = 1; i <= RECOVER; i++) begin
         wait_falls(1);
         checkOutput("dma_recover_release", bus.drv_release, (i < RECOVER) ? 1'b1 : 1'b0);
      end
      checkOutput("dma_recover_hold", bus.hold_req, 1'b0);
      checkOutput("dma_recover_lost", bus.pi_bus_lost, 1'b0);

      // Request arriving while the Pi owns an active cycle.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         wait_falls(1);
         checkOutput("busy_bg_n", bus.m68k_bg_n, 1'b1);
         checkOutput("busy_hold", bus.hold_req, 1'b1);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("busy_then_grant", bus.m68k_bg_n, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      wait_falls(1 + RECOVER);
      checkOutput("busy_settle_release", bus.drv_release, 1'b0);

      // Withdrawn while pending.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      wait_falls(1);
      checkOutput("wd_pend_hold", bus.hold_req, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("wd_pend_own_hold", bus.hold_req, 1'b0);
      checkOutput("wd_pend_own_bg", bus.m68k_bg_n, 1'b1);

      // Withdrawn while granted.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      wait_falls(2);
      checkOutput("wd_grant_bg", bus.m68k_bg_n, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("wd_recover_bg", bus.m68k_bg_n, 1'b1);
      checkOutput("wd_recover_release", bus.drv_release, 1'b1);
      wait_falls(RECOVER);
      checkOutput("wd_done_release", bus.drv_release, 1'b0);

      // Back-to-back request handed straight from OWNED to GRANT.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      wait_falls(2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("b2b_owned_bg", bus.m68k_bg_n, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("b2b_regrant_bg", bus.m68k_bg_n, 1'b0);
      checkOutput("b2b_release_kept", bus.drv_release, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      wait_falls(1 + RECOVER);
      checkOutput("b2b_done_release", bus.drv_release, 1'b0);

      // Grant never acknowledged.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      wait_falls(2);
      checkOutput("to_grant_bg", bus.m68k_bg_n, 1'b0);
      n = 0;
      while (n < 100 && bus.m68k_bg_n === 1'b0) begin wait_falls(1); n++; end
`ifdef PISTORM_ARB_TIMEOUT_EN
      checkOutput("to_fall_count", n, GRANT_TIMEOUT);
      checkOutput("to_flag", bus.arb_timeout, 1'b1);
`else
      checkOutput("no_to_fall_count", n, 100);
      checkOutput("no_to_bg_n", bus.m68k_bg_n, 1'b0);
`endif
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      wait_falls(2 + RECOVER);
      checkOutput("to_settle_release", bus.drv_release, 1'b0);

      // Asynchronous reset while an external master owns the bus.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      wait_falls(2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      wait_falls(1);
      checkOutput("ares_owned_release", bus.drv_release, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("ares_bg_n", bus.m68k_bg_n, 1'b1);
      checkOutput("ares_release", bus.drv_release, 1'b0);
      checkOutput("ares_hold", bus.hold_req, 1'b0);
      checkOutput("ares_lost", bus.pi_bus_lost, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge c200m);
      #1 rst_n = 1'b1;
      wait_falls(2);

      // Random handshake traffic; the compare process checks every cycle.
      br = 1'b1; bgack = 1'b1; as_n = 1'b1; idle = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge c200m);
         #1;
         if ($urandom_range(0, 39) == 0) br = ~br;
         if ($urandom_range(0, 29) == 0) bgack = ~bgack;
         if ($urandom_range(0, 19) == 0) as_n = ~as_n;
         if ($urandom_range(0, 24) == 0) idle = ~idle;
         applyStimulus(br, bgack, as_n, idle);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/pistorm_bus_arbiter.md
Name: pistorm_bus_arbiter

Overview:
- Controls 68000 bus arbitration (BR/BG/BGACK) between the PiStorm bus FSM and external bus masters, e.g. Amiga DMA or Zorro cards.
- Stops the bus FSM from starting new cycles, asserts BG at a clean cycle boundary, tri-states PiStorm drivers while an external master owns the bus, and returns the bus afterwards.
- Runs on the 200 MHz Pi clock domain and samples M68K_CLK as data.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for m68k_br_n, m68k_bgack_n and m68k_as_n (min 2).
- RECOVER_CLKS, 2, number of c7m falling edges drivers stay released after BGACK/BR negate (1..15).
- GRANT_TIMEOUT, 16, number of c7m falling edges allowed in GRANT before the grant is withdrawn (ARB_TIMEOUT_EN only; 1..255).

Ports:
- c200m  in  1  system clock (PI_CLK)
- rst_n  in  1  asynchronous reset, active-low
- m68k_clk  in  1  M68K_CLK, sampled as data
- m68k_br_n  in  1  bus request from external master
- m68k_bgack_n  in  1  bus grant acknowledge
- m68k_as_n  in  1  bus AS (own or external)
- bus_idle  in  1  bus FSM is in Sr with no request latched
- m68k_bg_n  out  1  bus grant to external master
- hold_req  out  1  high = bus FSM must not accept a new op_req
- drv_release  out  1  high = tri-state AS/UDS/LDS/RW/FC and all latch OEs
- pi_bus_lost  out  1  status bit for Pi REG_STATUS reads
- arb_timeout  out  1  sticky grant-timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: m68k_bg_n=1, hold_req=0, drv_release=0, pi_bus_lost=0, arb_timeout=0.
  - State OWN; counters 0; synchronisers cleared to 1.
- Synchronisers: br_s, bgack_s, as_s are SYNC_STAGES-deep on c200m. m68k_clk goes through a 3-flop chain; c7m_fall = bit[2]&!bit[1].
- Timing: every state or output change happens only in a c200m cycle where c7m_fall=1. All outputs are registered.
- OWN: if br_s=0, go to PEND and set hold_req=1.
- PEND (hold_req=1):
  - If br_s=1 (request withdrawn): go to OWN, hold_req=0.
  - Otherwise, after at least one c7m_fall spent in PEND, if bus_idle=1 and as_s=1: go to GRANT with m68k_bg_n=0 and drv_release=1.
  - bus_idle=0 keeps the block in PEND indefinitely.
- GRANT (m68k_bg_n=0, drv_release=1, pi_bus_lost=1):
  - If bgack_s=0 and as_s=1: go to OWNED, m68k_bg_n=1.
  - Else if br_s=1: withdrawn; go to RECOVER, m68k_bg_n=1.
  - If both occur in the same cycle, BGACK wins and the next state is OWNED.
- OWNED (m68k_bg_n=1, drv_release=1, pi_bus_lost=1):
  - If bgack_s=1 and br_s=0: back-to-back request; go to GRANT, m68k_bg_n=0.
  - If bgack_s=1 and br_s=1: go to RECOVER.
- RECOVER (drv_release=1, hold_req=1):
  - Counts RECOVER_CLKS c7m_fall edges, then goes to OWN with drv_release=0, hold_req=0, pi_bus_lost=0.
  - br_s=0 at any point goes to GRANT immediately, counter cleared.
- hold_req=1 in every state except OWN.
- m68k_bg_n is never low while drv_release=0.
- Reset mid-operation: all outputs return to reset values asynchronously. The external master must re-request.

Optional Feature:
- PISTORM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter increments on each c7m_fall in GRANT.
  - When it reaches GRANT_TIMEOUT with bgack_s still 1, set m68k_bg_n=1, arb_timeout=1 (sticky until rst_n), and go to RECOVER.
  - The counter clears on every GRANT entry.
- Not defined: GRANT is held indefinitely while br_s=0. arb_timeout is tied to 0 and no counter is synthesised.

Test Plan:
- Basic DMA: br_n=0, bus_idle=1, as_n=1 → bg_n low within 2 c7m falls after PEND entry; bgack_n=0 then br_n=1 → bg_n high next fall; bgack_n=1 → drv_release low after exactly RECOVER_CLKS=2 falls, hold_req=0, pi_bus_lost=0.
- Request during Pi cycle: br_n=0 while bus_idle=0 for 10 c7m cycles → bg_n stays 1, hold_req=1 throughout; bus_idle=1 → bg_n=0 on the next fall.
- Withdrawn request: br_n=0 for 1 c7m cycle, then br_n=1 before BGACK → returns to OWN (via PEND) or RECOVER (via GRANT); bg_n ends at 1 and drv_release=0 after recovery.
- Back-to-back: in OWNED, release bgack_n while br_n=0 → GRANT directly, bg_n=0, drv_release never drops.
- Timeout (PISTORM_ARB_TIMEOUT_EN, GRANT_TIMEOUT=16): br_n=0, bgack_n held 1 → bg_n=1 and arb_timeout=1 on the 16th fall in GRANT; without the macro, bg_n is still 0 after 100 falls.
- Async reset in OWNED: rst_n=0 → bg_n=1, drv_release=0, hold_req=0 immediately, with no c200m edge required.
